// File: rtl/pdm_decoder.sv
// ---------------------------------------------------------------------------
// pdm_decoder
//
// Receive end of the 1-bit sigma-delta audio path. A 1-bit pulse-density
// stream is turned back into a multibit level by integrate-and-dump over a
// fixed window of 2**(MSBI+1) enabled samples. A hysteresis slicer on each
// recovered level produces a clean tape-in bit for the tape/ear logic.
//
// Parameters
//   MSBI   output MSB index; q is MSBI+1 bits; window = 2**(MSBI+1) samples
//   THI    slicer rising threshold  (tape -> 1 when level >= THI)
//   TLO    slicer falling threshold (tape -> 0 when level <= TLO), TLO < THI
//
// Ports
//   clock  in   1        system clock
//   reset  in   1        asynchronous, active-high reset
//   ce     in   1        sample enable; one input sample per clock with ce=1
//   d      in   1        PDM bitstream, asynchronous to clock
//   q      out  MSBI+1   recovered level, 0 .. 2**(MSBI+1)-1
//   valid  out  1        one-clock strobe; q and tape change on the same edge
//   tape   out  1        hysteresis-sliced tape bit
// ---------------------------------------------------------------------------
module pdm_decoder #(
    parameter int MSBI = 9,
    parameter int THI  = 640,
    parameter int TLO  = 384
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce,
    input  logic          d,
    output logic [MSBI:0] q,
    output logic          valid,
    output logic          tape
);

    localparam int QW = MSBI + 1;   // level / index width
    localparam int AW = MSBI + 2;   // accumulator width, holds a full window

    localparam logic [MSBI:0] THI_L = QW'(THI);
    localparam logic [MSBI:0] TLO_L = QW'(TLO);

    logic          d_meta;
    logic          ds;
    logic [AW-1:0] acc;
    logic [AW-1:0] sum;
    logic [MSBI:0] idx;
    logic [MSBI:0] level;
    logic          last;

    // Two-flop synchroniser for the asynchronous bitstream. It runs every
    // clock, independent of ce, so the sampling latency is always two clocks.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, whatever the statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            d_meta <= 1'b0;
            ds     <= 1'b0;
        end else begin
            d_meta <= d;
            ds     <= d_meta;
        end
    end

    // Window sum including the sample taken on this edge. A window of all
    // ones sums to 2**(MSBI+1), which does not fit in q; it is clamped to
    // all-ones so full scale never wraps to zero.
    // NOTE: every signal of this block is assigned on every path, so no
    // latch can be inferred.
    always_comb begin
        sum   = acc + AW'(ds);
        level = sum[AW-1] ? '1 : sum[MSBI:0];
        last  = &idx;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            idx   <= '0;
            q     <= '0;
            valid <= 1'b0;
            tape  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (ce) begin
                if (last) begin
                    // Dump: publish the window and restart from zero, so
                    // consecutive windows never overlap.
                    q     <= level;
                    valid <= 1'b1;
                    acc   <= '0;
                    idx   <= '0;
                    // Hysteresis: levels between the thresholds keep the
                    // previous tape bit.
                    if (level >= THI_L) begin
                        tape <= 1'b1;
                    end else if (level <= TLO_L) begin
                        tape <= 1'b0;
                    end
                end else begin
                    acc <= sum;
                    idx <= idx + QW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pdm_decoder.sv
// ---------------------------------------------------------------------------
// tb_pdm_decoder
//
// Self-checking bench for pdm_decoder with default parameters (window 1024,
// thresholds 640/384). A window-level reference model (sample counter, ones
// counter, two-deep delay queue for the synchroniser) is compared against the
// DUT outputs after every clock; a table of per-window ones counts and a few
// hand-written sequences check the documented corner cases with constants.
// ---------------------------------------------------------------------------
module tb_pdm_decoder;

    localparam int WIN = 1024;

    logic       clock;
    logic       reset;
    logic       ce;
    logic       d;
    logic [9:0] q;
    logic       valid;
    logic       tape;

    pdm_decoder #(.MSBI(9), .THI(640), .TLO(384)) dut (
        .clock (clock),
        .reset (reset),
        .ce    (ce),
        .d     (d),
        .q     (q),
        .valid (valid),
        .tape  (tape)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic       dq[$];      // d values still travelling through the synchroniser
    int         m_ones;
    int         m_samples;
    logic [9:0] m_q;
    logic       m_valid;
    logic       m_tape;

    task automatic model_reset();
        dq        = '{1'b0, 1'b0};
        m_ones    = 0;
        m_samples = 0;
        m_q       = '0;
        m_valid   = 1'b0;
        m_tape    = 1'b0;
    endtask

    task automatic model_edge(input logic dv, input logic cev);
        logic s;
        int   lvl;
        s = dq.pop_front();
        dq.push_back(dv);
        m_valid = 1'b0;
        if (cev) begin
            m_ones    += int'(s);
            m_samples += 1;
            if (m_samples == WIN) begin
                lvl       = (m_ones > WIN - 1) ? WIN - 1 : m_ones;
                m_q       = 10'(lvl);
                m_valid   = 1'b1;
                if (lvl >= 640)      m_tape = 1'b1;
                else if (lvl <= 384) m_tape = 1'b0;
                m_ones    = 0;
                m_samples = 0;
            end
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare #1 later.
    task automatic cycle(input logic dv, input logic cev);
        d  = dv;
        ce = cev;
        @(posedge clock);
        if (reset) model_reset();
        else       model_edge(dv, cev);
        #1;
        check("outs_vs_model", int'({q, valid, tape}), int'({m_q, m_valid, m_tape}));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check("reset_outs", int'({q, valid, tape}), 0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    // ---------------- level table ----------------
    typedef struct {
        int ones;      // ones at the start of the window, zeros after
        int exp_q;
        int exp_tape;
    } vec_t;

    vec_t tbl[12];

    function automatic logic bit_at(input int c);
        int j;
        int i;
        j = c / WIN;
        i = c % WIN;
        if (j >= 12) return 1'b0;
        return (i < tbl[j].ones) ? 1'b1 : 1'b0;
    endfunction

    initial begin
        int last_v;
        int nv;
        int width;

        tbl[0]  = '{0,    0,    0};
        tbl[1]  = '{1024, 1023, 1};   // full scale saturates
        tbl[2]  = '{512,  512,  1};   // between thresholds: hold 1
        tbl[3]  = '{700,  700,  1};
        tbl[4]  = '{500,  500,  1};   // hold
        tbl[5]  = '{300,  300,  0};
        tbl[6]  = '{512,  512,  0};   // between thresholds: hold 0
        tbl[7]  = '{640,  640,  1};   // exactly THI
        tbl[8]  = '{385,  385,  1};   // one above TLO: hold
        tbl[9]  = '{384,  384,  0};   // exactly TLO
        tbl[10] = '{639,  639,  0};   // one below THI: hold
        tbl[11] = '{1023, 1023, 1};

        d     = 1'b0;
        ce    = 1'b0;
        reset = 1'b1;
        model_reset();

        // ---- d=0 constant, three windows ----
        do_reset();
        last_v = -1;
        nv     = 0;
        for (int i = 0; i < 3 * WIN; i++) begin
            cycle(1'b0, 1'b1);
            if (valid) begin
                if (last_v < 0) check("zero_first_valid", i, WIN - 1);
                else            check("zero_valid_period", i - last_v, WIN);
                check("zero_q", int'(q), 0);
                check("zero_tape", int'(tape), 0);
                last_v = i;
                nv++;
            end
        end
        check("zero_valid_count", nv, 3);

        // ---- table of window levels ----
        // The first two bits are pre-loaded with ce=0 so that the sample seen
        // on ce edge c (two clocks of synchroniser delay) is table bit c.
        do_reset();
        cycle(bit_at(0), 1'b0);
        cycle(bit_at(1), 1'b0);
        for (int c = 0; c < 12 * WIN; c++) begin
            cycle(bit_at(c + 2), 1'b1);
            if ((c % WIN) == WIN - 1) begin
                check("tbl_valid", int'(valid), 1);
                check("tbl_q", int'(q), tbl[c / WIN].exp_q);
                check("tbl_tape", int'(tape), tbl[c / WIN].exp_tape);
            end
        end

        // ---- alternating 1,0 with tape preloaded to 1, then to 0 ----
        // The first alternating window still holds two trailing samples from
        // before, so the exact 512 is checked on the second window.
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < WIN; i++) cycle(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b1);
        end
        check("alt1_q", int'(q), 512);
        check("alt1_tape", int'(tape), 1);
        for (int i = 0; i < WIN; i++) cycle(1'b0, 1'b1);
        check("preload0_tape", int'(tape), 0);
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < WIN; i++) cycle(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b1);
        end
        check("alt0_q", int'(q), 512);
        check("alt0_tape", int'(tape), 0);

        // ---- ce every 4th clock, d=1 ----
        do_reset();
        last_v = -1;
        nv     = 0;
        width  = 0;
        for (int i = 0; i < 8 * WIN + 8; i++) begin
            cycle(1'b1, ((i % 4) == 0) ? 1'b1 : 1'b0);
            if (valid) begin
                if (last_v < 0) check("ce4_first_valid", i, 4 * (WIN - 1));
                else            check("ce4_valid_period", i - last_v, 4 * WIN);
                check("ce4_q", int'(q), 1023);
                check("ce4_tape", int'(tape), 1);
                last_v = i;
                nv++;
                width++;
            end else if (width != 0) begin
                check("ce4_valid_width", width, 1);
                width = 0;
            end
        end
        check("ce4_valid_count", nv, 2);

        // ---- reset mid-window (idx=600, d=1), then a window of zeros ----
        do_reset();
        for (int i = 0; i < 600; i++) cycle(1'b1, 1'b1);
        reset = 1'b1;
        model_reset();
        #1;
        check("midrst_async_outs", int'({q, valid, tape}), 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1);
            check("midrst_held_outs", int'({q, valid, tape}), 0);
        end
        reset = 1'b0;
        last_v = -1;
        for (int i = 0; i < WIN + 4; i++) begin
            cycle(1'b0, 1'b1);
            if (valid && last_v < 0) last_v = i;
        end
        check("midrst_first_valid", last_v, WIN - 1);
        check("midrst_q", int'(q), 0);
        check("midrst_tape", int'(tape), 0);

        // ---- randomized stream against the model ----
        do_reset();
        for (int i = 0; i < 6 * WIN; i++) begin
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end
        // Biased streams to exercise both slicer thresholds.
        for (int i = 0; i < 3 * WIN; i++) begin
            cycle(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, 1'b1);
        end
        for (int i = 0; i < 3 * WIN; i++) begin
            cycle(($urandom_range(0, 9) < 2) ? 1'b1 : 1'b0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
